// File: rtl/npc_ras_unit.sv
// npc_ras_unit: fetch-PC register with decode-stage branch/jump resolution and an optional return-address stack.
// Define NPC_RAS_EN to build the return-address stack that predicts jr $31 targets.
module npc_ras_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(32'h0000_3000),
    parameter int                RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall_i,
    input  logic [31:0]                  instr_D,
    input  logic [ADDR_W-1:0]            PC_D,
    input  logic [31:0]                  rs_val_D,
    input  logic [31:0]                  rt_val_D,
    input  logic                         rs_ready_D,
    output logic [ADDR_W-1:0]            PC_F,
    output logic                         redirect_o,
    output logic                         stall_req_o,
    output logic                         ras_pred_o,
    output logic [$clog2(RAS_DEPTH):0]   ras_count_o
);
    logic [5:0]        op;
    logic              is_beq, is_bne, is_j, is_jal, is_jr, rs_eq;
    logic [ADDR_W-1:0] br_tgt, j_tgt, jr_tgt, tgt, ras_top, pc_d, pc_q;

    assign op     = instr_D[31:26];
    assign is_beq = op == 6'b000100;
    assign is_bne = op == 6'b000101;
    assign is_j   = op == 6'b000010;
    assign is_jal = op == 6'b000011;
    assign is_jr  = op == 6'b000000 && instr_D[5:0] == 6'b001000;
    assign rs_eq  = rs_val_D == rt_val_D;

`ifdef NPC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic              rs_is_ra, push, pop;

    // ptr_q is the next free slot; the newest entry sits just below it
    assign rs_is_ra    = instr_D[25:21] == 5'd31;
    assign ras_top     = ras_q[ptr_q - PW'(1)];
    assign ras_pred_o  = is_jr && !rs_ready_D && rs_is_ra && cnt_q != '0;
    assign push        = is_jal && !stall_i;
    assign pop         = is_jr && !stall_req_o && rs_is_ra && !stall_i && cnt_q != '0;
    assign ras_count_o = cnt_q;

    always_comb begin
        ptr_d = push ? ptr_q + PW'(1) : pop ? ptr_q - PW'(1) : ptr_q;
        cnt_d = push ? (cnt_q == (PW+1)'(RAS_DEPTH) ? cnt_q : cnt_q + 1'b1) : pop ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk)
        if (push) ras_q[ptr_q] <= PC_D + ADDR_W'(8);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
`else
    assign ras_top     = '0;
    assign ras_pred_o  = 1'b0;
    assign ras_count_o = '0;
`endif

    assign br_tgt      = PC_D + ADDR_W'(4) + ADDR_W'($signed({instr_D[15:0], 2'b00}));
    assign j_tgt       = {PC_D[ADDR_W-1:28], instr_D[25:0], 2'b00};
    assign jr_tgt      = ras_pred_o ? ras_top : ADDR_W'(rs_val_D);
    assign stall_req_o = is_jr && !rs_ready_D && !ras_pred_o;
    assign redirect_o  = is_j || is_jal || (is_jr && !stall_req_o) || (is_beq && rs_eq) || (is_bne && !rs_eq);
    assign tgt         = is_jr ? jr_tgt : (is_j || is_jal) ? j_tgt : br_tgt;
    assign PC_F        = pc_q;

    always_comb begin
        pc_d = (stall_i || stall_req_o) ? pc_q : redirect_o ? tgt : pc_q + ADDR_W'(4);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
endmodule

// File: tb/tb_npc_ras_unit.sv
// tb_npc_ras_unit: table vectors, directed corner sequences and random stimulus against a queue-based reference model.
module tb_npc_ras_unit;
    localparam int RAS_DEPTH = 4;
`ifdef NPC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif
    localparam logic [31:0] NOP  = 32'h0;
    localparam logic [31:0] JR31 = 32'h03E0_0008;

    logic        clk = 1'b0, reset = 1'b0, stall_i = 1'b0, rs_ready_D = 1'b0;
    logic [31:0] instr_D = '0, PC_D = '0, rs_val_D = '0, rt_val_D = '0, PC_F;
    logic        redirect_o, stall_req_o, ras_pred_o;
    logic [2:0]  ras_count_o;

    int          n_err = 0, n_chk = 0;
    logic [31:0] pc_m;
    logic [31:0] ras_m[$];

    npc_ras_unit #(.ADDR_W(32), .RESET_PC(32'h0000_3000), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .instr_D(instr_D), .PC_D(PC_D),
        .rs_val_D(rs_val_D), .rt_val_D(rt_val_D), .rs_ready_D(rs_ready_D), .PC_F(PC_F),
        .redirect_o(redirect_o), .stall_req_o(stall_req_o), .ras_pred_o(ras_pred_o),
        .ras_count_o(ras_count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // called at a falling edge; drives one decode slot, checks it, returns at the next falling edge
    task automatic step(input logic [31:0] ins, input logic [31:0] pcd, input logic [31:0] rs,
                        input logic [31:0] rt, input logic rdy, input logic st,
                        output logic red, output logic sreq);
        logic [5:0]  op;
        logic        is_jr, ra, e_pred, e_sreq, e_red;
        logic [31:0] tgt;
        int          imm;
        instr_D = ins; PC_D = pcd; rs_val_D = rs; rt_val_D = rt; rs_ready_D = rdy; stall_i = st;
        op = ins[31:26];
        is_jr = op == 6'd0 && ins[5:0] == 6'h08;
        ra = ins[25:21] == 5'd31;
        e_pred = 1'b0; e_sreq = 1'b0; tgt = rs;
        if (is_jr && !rdy) begin
            if (RAS_EN && ra && ras_m.size() > 0) begin
                e_pred = 1'b1;
                tgt = ras_m[$];
            end else e_sreq = 1'b1;
        end
        if (op == 6'd2 || op == 6'd3) tgt = {pcd[31:28], ins[25:0], 2'b00};
        imm = int'($signed(ins[15:0]));
        if (op == 6'd4 || op == 6'd5) tgt = pcd + 32'd4 + 32'(imm * 4);
        e_red = op == 6'd2 || op == 6'd3 || (is_jr && !e_sreq) || (op == 6'd4 && rs == rt) || (op == 6'd5 && rs != rt);
        #1;
        red = redirect_o; sreq = stall_req_o;
        chk("redirect", 32'(redirect_o), 32'(e_red));
        chk("stall_req", 32'(stall_req_o), 32'(e_sreq));
        chk("ras_pred", 32'(ras_pred_o), 32'(e_pred));
        @(posedge clk); #1;
        if (!st && !e_sreq) begin
            pc_m = e_red ? tgt : pc_m + 32'd4;
            if (RAS_EN && op == 6'd3) begin
                ras_m.push_back(pcd + 32'd8);
                if (ras_m.size() > RAS_DEPTH) void'(ras_m.pop_front());
            end else if (RAS_EN && is_jr && ra && ras_m.size() > 0) void'(ras_m.pop_back());
        end
        chk("pc_f", PC_F, pc_m);
        chk("ras_count", 32'(ras_count_o), 32'(ras_m.size()));
        @(negedge clk);
    endtask

    task automatic do_reset();
        instr_D = NOP; stall_i = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pc_m = 32'h3000;
        ras_m.delete();
    endtask

    typedef struct {
        logic [31:0] ins, pcd, rs, rt;
        logic        rdy, st, e_red, e_sreq;
    } vec_t;

    initial begin
        vec_t        tbl[12];
        logic        red, sreq;
        logic [31:0] pc_b, cnt_b;
        tbl[0]  = '{32'h1022_FFFC, 32'h3010, 32'd5, 32'd5, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{32'h1022_FFFC, 32'h3010, 32'd5, 32'd6, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{32'h1422_0008, 32'h3040, 32'd1, 32'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{32'h1422_0008, 32'h3040, 32'd7, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{32'h0800_0C00, 32'h3000, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{32'h0040_0008, 32'h3050, 32'h3100, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{32'h0040_0008, 32'h3050, 32'h3100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{32'h0022_1820, 32'h3060, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{32'h0040_0009, 32'h3070, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{32'h1022_0010, 32'h3080, 32'd9, 32'd9, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{32'h8C22_0000, 32'h3090, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{32'h0C00_0D00, 32'h30A0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0};

        #1 reset = 1'b1;
        #2;
        chk("reset_pc", PC_F, 32'h3000);
        chk("reset_count", 32'(ras_count_o), 32'd0);
        @(negedge clk); @(negedge clk);
        chk("reset_hold_pc", PC_F, 32'h3000);
        reset = 1'b0;
        pc_m = 32'h3000;
        ras_m.delete();
        chk("release_pc", PC_F, 32'h3000);
        step(NOP, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0, red, sreq);
        chk("seq_pc1", PC_F, 32'h3004);
        step(NOP, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0, red, sreq);
        chk("seq_pc2", PC_F, 32'h3008);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].ins, tbl[i].pcd, tbl[i].rs, tbl[i].rt, tbl[i].rdy, tbl[i].st, red, sreq);
            chk($sformatf("tbl%0d_redirect", i), 32'(red), 32'(tbl[i].e_red));
            chk($sformatf("tbl%0d_stall_req", i), 32'(sreq), 32'(tbl[i].e_sreq));
            if (i == 0) chk("beq_taken_pc", PC_F, 32'h3004);
        end

        do_reset();
        step(32'h0C00_0D00, 32'h3020, 32'd0, 32'd0, 1'b1, 1'b0, red, sreq);
        chk("jal_pc", PC_F, 32'h3400);
        chk("jal_count", 32'(ras_count_o), RAS_EN ? 32'd1 : 32'd0);
        step(JR31, 32'h3400, 32'hDEAD_BEE0, 32'd0, 1'b0, 1'b0, red, sreq);
        chk("jr_ras_pc", PC_F, RAS_EN ? 32'h3028 : 32'h3400);
        chk("jr_ras_sreq", 32'(sreq), RAS_EN ? 32'd0 : 32'd1);
        chk("jr_ras_count", 32'(ras_count_o), 32'd0);

        do_reset();
        for (int i = 0; i < 5; i++)
            step(32'h0C00_0D00, 32'h3100 + 32'(i) * 32'h100, 32'd0, 32'd0, 1'b1, 1'b0, red, sreq);
        chk("ras_sat_count", 32'(ras_count_o), RAS_EN ? 32'd4 : 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(JR31, 32'h3400, 32'd0, 32'd0, 1'b0, 1'b0, red, sreq);
            chk($sformatf("pop%0d_pc", i), PC_F, RAS_EN ? 32'h3508 - 32'(i) * 32'h100 : 32'h3400);
        end
        step(JR31, 32'h3400, 32'd0, 32'd0, 1'b0, 1'b0, red, sreq);
        chk("empty_pop_sreq", 32'(sreq), 32'd1);

        pc_b = PC_F; cnt_b = 32'(ras_count_o);
        step(32'h0C00_0D00, 32'h3600, 32'd0, 32'd0, 1'b1, 1'b1, red, sreq);
        chk("stall_jal_pc", PC_F, pc_b);
        chk("stall_jal_count", 32'(ras_count_o), cnt_b);

        step(32'h0BFF_FFFF, 32'hF000_0000, 32'd0, 32'd0, 1'b1, 1'b0, red, sreq);
        chk("wrap_top", PC_F, 32'hFFFF_FFFC);
        step(NOP, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0, red, sreq);
        chk("wrap_zero", PC_F, 32'h0);

        step(32'h0C00_0D00, 32'h3000, 32'd0, 32'd0, 1'b1, 1'b0, red, sreq);
        instr_D = 32'h0800_0100; PC_D = 32'h3400; stall_i = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pc", PC_F, 32'h3000);
        chk("async_rst_count", 32'(ras_count_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pc_m = 32'h3000;
        ras_m.delete();
        step(NOP, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0, red, sreq);
        chk("post_rst_pc", PC_F, 32'h3004);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins, pcd, rs, rt;
            int          k;
            k   = int'($urandom_range(0, 7));
            pcd = 32'h3000 + ($urandom_range(0, 1023) << 2);
            rs  = $urandom_range(0, 3);
            rt  = $urandom_range(0, 3);
            case (k)
                0: ins = {6'h04, 10'h022, 16'($urandom)};
                1: ins = {6'h05, 10'h022, 16'($urandom)};
                2: ins = {6'h02, 26'($urandom)};
                3, 4: ins = {6'h03, 26'($urandom)};
                5: ins = JR31;
                6: ins = {6'h00, 5'($urandom), 15'h0, 6'h08};
                default: ins = {6'($urandom_range(6, 63)), 26'($urandom)};
            endcase
            if (k >= 5) rs = $urandom & 32'hFFFF_FFFC;
            step(ins, pcd, rs, rt, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0), red, sreq);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/npc_ras_unit.md
NPC_RAS_UNIT -- requirements
Module: npc_ras_unit

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, width of every PC/address port.
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_3000, fetch PC after reset.
REQ-003 SHALL provide parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port stall_i  input  1  hazard-unit stall; holds PC_F and RAS.
REQ-007 SHALL have port instr_D  input  32  decode-stage instruction.
REQ-008 SHALL have port PC_D  input  ADDR_W  decode-stage PC.
REQ-009 SHALL have ports rs_val_D, rt_val_D  input  32  forwarded GPR[rs], GPR[rt].
REQ-010 SHALL have port rs_ready_D  input  1  rs_val_D is final (no pending producer).
REQ-011 SHALL have port PC_F  output  ADDR_W  registered fetch PC.
REQ-012 SHALL have port redirect_o  output  1  current D instruction changes control flow (taken).
REQ-013 SHALL have port stall_req_o  output  1  request stall; jr target unavailable.
REQ-014 SHALL have port ras_pred_o  output  1  jr target taken from RAS, not rs_val_D.
REQ-015 SHALL have port ras_count_o  output  log2(RAS_DEPTH)+1  valid RAS entries.

Function
REQ-016 SHALL decode from instr_D: beq (op 000100), bne (000101), j (000010), jal (000011), jr (op 000000, funct 001000); all other encodings are sequential.
REQ-017 SHALL compute targets: branch = PC_D+4+(sign-extended imm16<<2); j/jal = {PC_D[ADDR_W-1:28], instr_D[25:0], 2'b00}; jr = selected jr source (REQ-019).
REQ-018 SHALL assert redirect_o combinationally for j, jal, jr-with-target, beq with rs_val_D==rt_val_D, bne with rs_val_D!=rt_val_D.
REQ-019 SHALL select jr source: rs_ready_D=1 -> rs_val_D; else, with RAS_EN, rs field==31 and count>0 -> RAS top, ras_pred_o=1; else stall_req_o=1, redirect_o=0.
REQ-020 SHALL update PC_F each edge: stall_i=1 or stall_req_o=1 -> hold; redirect_o=1 -> target; else PC_F+4 (modulo 2^ADDR_W, wraps).
REQ-021 SHALL, on jal with stall_i=0, push PC_D+8 onto RAS; push when full overwrites oldest entry, count stays RAS_DEPTH.
REQ-022 SHALL, on taken jr with rs field==31 and stall_i=0, pop RAS; pop when empty leaves count 0 and pointer unchanged.
REQ-023 SHALL make no RAS change when stall_i=1 or stall_req_o=1; push and pop never occur in one cycle.
REQ-024 SHALL use a circular pointer wrapping modulo RAS_DEPTH for push and pop.

Reset
REQ-025 SHALL, while reset=1, force PC_F=RESET_PC, RAS count=0, pointer=0, independent of clk.
REQ-026 SHALL leave RAS entry contents undefined after reset; they are not read while count=0.
REQ-027 SHALL, on reset asserted mid-stall or mid-redirect, discard that cycle's update; first edge after release loads RESET_PC+4 unless stall/redirect.

Configuration
REQ-028 SHALL compile the RAS only when macro NPC_RAS_EN is defined.
REQ-029 SHALL, without NPC_RAS_EN, omit RAS storage, tie ras_pred_o=0 and ras_count_o=0, and stall every jr with rs_ready_D=0.

Verification
REQ-030 SHALL cover: reset release, no branches -> PC_F 0x3000, 0x3004, 0x3008 on consecutive edges.
REQ-031 SHALL cover: beq PC_D=0x3010, imm=0xFFFC, rs_val_D==rt_val_D -> redirect_o=1, next PC_F=0x3004; unequal -> PC_F+4.
REQ-032 SHALL cover: jal PC_D=0x3020 target 0x3400 -> PC_F=0x3400, ras_count_o 0->1; then jr $31, rs_ready_D=0 -> ras_pred_o=1, PC_F=0x3028, count 1->0.
REQ-033 SHALL cover: RAS_DEPTH=4, five jal pushes -> count saturates at 4; four jr $31 pops return 2nd..5th addresses newest-first; fifth pop with rs_ready_D=0 -> stall_req_o=1.
REQ-034 SHALL cover: stall_i=1 during jal -> PC_F and ras_count_o unchanged; build without NPC_RAS_EN, jr with rs_ready_D=0 -> stall_req_o=1, PC_F held.
REQ-035 SHALL cover: reset asserted asynchronously between edges during redirect -> PC_F=0x3000 immediately, ras_count_o=0.
